// File: rtl/spike_pkg.sv
// Shared types and default sizing for the time-to-first-spike encoder.
// Defaults mirror num_spikes / WBITS used by the neuron layer.
package spike_pkg;

  localparam int NUM_SPIKES = 4;
  localparam int WBITS      = 3;
  localparam int VBITS_DEF  = WBITS;
  localparam int GAMMA_DEF  = 2 ** VBITS_DEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_lane.sv
// One encoder lane: captured spike time and enable, compare against the window
// counter, and a registered spike output that doubles as the STEP hold flop.
module spike_lane #(
  parameter int VBITS = 3,
  parameter int TW    = 3,
  parameter int STEP  = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [VBITS-1:0] value_i,
  input  logic             en_i,
  input  logic [TW-1:0]    t_next_i,
  input  logic             run_next_i,
  input  logic             start_next_i,
  output logic             spike_o
);

  logic [VBITS-1:0] value_q, value_d;
  logic             en_q, en_d;
  logic             spike_q, spike_d;
  logic             fire;

  // Output is computed from next-cycle state so the registered spike lines up
  // with the window cycle it belongs to.
  always_comb begin
    value_d = load_i ? value_i : value_q;
    en_d    = load_i ? en_i : en_q;
    fire    = run_next_i && en_d && (value_d == VBITS'(t_next_i));
    spike_d = fire;
    if (STEP != 0) begin
      spike_d = fire || (spike_q && run_next_i && !start_next_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      value_q <= '0;
      en_q    <= 1'b0;
      spike_q <= 1'b0;
    end else begin
      value_q <= value_d;
      en_q    <= en_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/spike_encoder.sv
// Time-to-first-spike encoder: turns a vector of intensities into one spike
// wave per GAMMA-cycle window; windows may run back-to-back.
module spike_encoder
  import spike_pkg::*;
#(
  parameter int N     = NUM_SPIKES,
  parameter int VBITS = VBITS_DEF,
  parameter int GAMMA = 2 ** VBITS,
  parameter int STEP  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][VBITS-1:0] in_values,
  input  logic [N-1:0]          in_en,
  output logic [N-1:0]          spikes_out,
  output logic                  win_start,
  output logic                  win_done,
  output logic                  busy,
  output enc_state_t            dbg_state
);

  localparam int TW = (GAMMA > 1) ? $clog2(GAMMA) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(GAMMA - 1);

  // Handshake: a request transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state and t.
  enc_state_t    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          accept;
  logic          run_next;
  logic          win_start_q, win_done_q, busy_q;

  assign in_ready = (state_q == IDLE) || ((state_q == RUN) && (t_q == T_LAST));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          t_d     = '0;
        end
      end
      RUN: begin
        if (t_q == T_LAST) begin
          t_d = '0;
          if (!accept) state_d = IDLE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  assign run_next = (state_d == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      win_start_q <= 1'b0;
      win_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      win_start_q <= run_next && (t_d == '0);
      win_done_q  <= run_next && (t_d == T_LAST);
      busy_q      <= run_next;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    spike_lane #(
      .VBITS(VBITS),
      .TW   (TW),
      .STEP (STEP)
    ) u_lane (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .load_i      (accept),
      .value_i     (in_values[i]),
      .en_i        (in_en[i]),
      .t_next_i    (t_d),
      .run_next_i  (run_next),
      .start_next_i(accept),
      .spike_o     (spikes_out[i])
    );
  end

  assign win_start = win_start_q;
  assign win_done  = win_done_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: three instances (pulse G=8, step G=8, pulse G=6)
// checked every cycle against a window-level reference model.
module tb_spike_encoder;
  import spike_pkg::*;

  localparam int NL = 4;
  localparam int VB = 3;
  localparam int ND = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [ND-1:0]          vld;
  logic [NL-1:0][VB-1:0]  vals;
  logic [NL-1:0]          en;
  logic [NL-1:0]          spk[ND];
  logic                   rdy[ND], ws[ND], wd[ND], bz[ND];
  enc_state_t             dbg[ND];

  spike_encoder #(.N(NL), .VBITS(VB), .GAMMA(8), .STEP(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_values(vals), .in_en(en), .spikes_out(spk[0]), .win_start(ws[0]),
    .win_done(wd[0]), .busy(bz[0]), .dbg_state(dbg[0]));
  spike_encoder #(.N(NL), .VBITS(VB), .GAMMA(8), .STEP(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_values(vals), .in_en(en), .spikes_out(spk[1]), .win_start(ws[1]),
    .win_done(wd[1]), .busy(bz[1]), .dbg_state(dbg[1]));
  spike_encoder #(.N(NL), .VBITS(VB), .GAMMA(6), .STEP(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_values(vals), .in_en(en), .spikes_out(spk[2]), .win_start(ws[2]),
    .win_done(wd[2]), .busy(bz[2]), .dbg_state(dbg[2]));

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit m_run[ND];
  int m_t[ND];
  int m_val[ND][NL];
  bit m_en[ND][NL];
  int ws_cnt[ND];
  int hi_cnt[ND][NL];

  function automatic int gam(int d);
    return (d == 2) ? 6 : 8;
  endfunction

  function automatic bit stp(int d);
    return d == 1;
  endfunction

  function automatic bit m_ready(int d);
    return !m_run[d] || (m_t[d] == gam(d) - 1);
  endfunction

  function automatic logic [NL-1:0] m_spk(int d);
    logic [NL-1:0] s;
    s = '0;
    for (int i = 0; i < NL; i++) begin
      if (m_run[d] && m_en[d][i] &&
          (stp(d) ? (m_t[d] >= m_val[d][i]) : (m_t[d] == m_val[d][i])))
        s[i] = 1'b1;
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      m_run[d] = 1'b0;
      m_t[d]   = 0;
      for (int i = 0; i < NL; i++) begin
        m_val[d][i] = 0;
        m_en[d][i]  = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      if (vld[d] && m_ready(d)) begin
        m_run[d] = 1'b1;
        m_t[d]   = 0;
        for (int i = 0; i < NL; i++) begin
          m_val[d][i] = int'(vals[i]);
          m_en[d][i]  = en[i];
        end
      end else if (m_run[d]) begin
        if (m_t[d] == gam(d) - 1) begin
          m_run[d] = 1'b0;
          m_t[d]   = 0;
        end else begin
          m_t[d] = m_t[d] + 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d.spikes", d), 32'(spk[d]), 32'(m_spk(d)));
      chk($sformatf("d%0d.win_start", d), 32'(ws[d]), 32'(m_run[d] && m_t[d] == 0));
      chk($sformatf("d%0d.win_done", d), 32'(wd[d]), 32'(m_run[d] && m_t[d] == gam(d) - 1));
      chk($sformatf("d%0d.busy", d), 32'(bz[d]), 32'(m_run[d]));
      chk($sformatf("d%0d.in_ready", d), 32'(rdy[d]), 32'(m_ready(d)));
      chk($sformatf("d%0d.state", d), 32'(dbg[d]), 32'(m_run[d]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
    for (int d = 0; d < ND; d++) begin
      if (ws[d] === 1'b1) ws_cnt[d]++;
      for (int i = 0; i < NL; i++)
        if (spk[d][i] === 1'b1) hi_cnt[d][i]++;
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < ND; d++) begin
      ws_cnt[d] = 0;
      for (int i = 0; i < NL; i++) hi_cnt[d][i] = 0;
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
  endtask

  task automatic set_vals(int v0, int v1, int v2, int v3);
    vals[0] = VB'(v0);
    vals[1] = VB'(v1);
    vals[2] = VB'(v2);
    vals[3] = VB'(v3);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    vld = '0;
    vals = '0;
    en = '0;
    model_clear();
    clear_counts();

    // reset, then idle
    #2;
    assert_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    // pulse / step encode, and a value beyond the G=6 window
    clear_counts();
    set_vals(0, 3, 7, 3);
    en = 4'b1111;
    vld = 3'b111;
    step();
    vld = '0;
    repeat (10) step();
    chk("pulse.d0.lane0", 32'(hi_cnt[0][0]), 32'd1);
    chk("pulse.d0.lane2", 32'(hi_cnt[0][2]), 32'd1);
    chk("step.d1.lane0", 32'(hi_cnt[1][0]), 32'd8);
    chk("step.d1.lane1", 32'(hi_cnt[1][1]), 32'd5);
    chk("step.d1.lane2", 32'(hi_cnt[1][2]), 32'd1);
    chk("g6.d2.lane2_silent", 32'(hi_cnt[2][2]), 32'd0);
    chk("pulse.d0.win_starts", 32'(ws_cnt[0]), 32'd1);

    // per-lane enables
    clear_counts();
    set_vals(2, 2, 2, 2);
    en = 4'b0101;
    vld = 3'b111;
    step();
    vld = '0;
    repeat (9) step();
    chk("enable.d0.lane0", 32'(hi_cnt[0][0]), 32'd1);
    chk("enable.d0.lane1", 32'(hi_cnt[0][1]), 32'd0);
    chk("enable.d0.lane2", 32'(hi_cnt[0][2]), 32'd1);
    chk("enable.d0.lane3", 32'(hi_cnt[0][3]), 32'd0);

    // back-to-back windows A then B with in_valid held high
    clear_counts();
    set_vals(1, 1, 1, 1);
    en = 4'b1111;
    vld = 3'b111;
    step();
    set_vals(0, 0, 0, 0);
    repeat (8) step();
    vld = '0;
    repeat (10) step();
    chk("b2b.d0.win_starts", 32'(ws_cnt[0]), 32'd2);
    chk("b2b.d1.win_starts", 32'(ws_cnt[1]), 32'd2);
    chk("b2b.d2.win_starts", 32'(ws_cnt[2]), 32'd2);

    // reset in the middle of a window
    set_vals(5, 4, 1, 6);
    en = 4'b1111;
    vld = 3'b111;
    step();
    vld = '0;
    repeat (4) step();
    #2;
    assert_reset();
    repeat (2) step();
    rst_n = 1'b1;
    set_vals(0, 2, 4, 6);
    vld = 3'b111;
    step();
    vld = '0;
    repeat (10) step();

    // randomized traffic with occasional resets
    repeat (500) begin
      vld  = 3'($urandom_range(0, 7));
      vals = 12'($urandom);
      en   = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Temporal (time-to-first-spike) encoder that converts one vector of input intensities into a spike wave over a fixed window of GAMMA cycles, one lane per input. Its spikes_out bus drives the spikes_in bus of the neuron layer directly, so encoder lane i feeds synapse i. Windows are accepted through a valid/ready handshake and can run back-to-back without a gap cycle.

## Interface
- N, default `num_spikes: number of lanes; must equal the neuron spikes_in width.
- VBITS, default 3: width of each input value.
- GAMMA, default 2**VBITS: window length in cycles; legal range 2..2**VBITS.
- STEP, default 0: 0 = single-cycle pulse at spike time; 1 = level held from spike time to end of window (race-logic step).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_values/in_en hold a new window request.
- in_ready  output  1  encoder accepts a request this cycle.
- in_values  input  [N-1:0][VBITS-1:0]  spike time per lane, in cycles from window start.
- in_en  input  N  per-lane enable; 0 = lane never spikes this window.
- spikes_out  output  N  registered spike bus to neurons.
- win_start  output  1  high during window cycle t=0.
- win_done  output  1  high during window cycle t=GAMMA-1.
- busy  output  1  high during every window cycle.

## Operation
- States: IDLE, RUN. Window counter t, width $clog2(GAMMA), counts 0..GAMMA-1.
- in_ready = (state==IDLE) || (state==RUN && t==GAMMA-1).
- Accept = in_valid && in_ready. On accept, capture in_values and in_en, set state RUN, t=0 in the next cycle.
- RUN, t<GAMMA-1: t increments by 1.
- RUN, t==GAMMA-1: with accept, start a new window (t=0, RUN, new captured data). Without accept, go to IDLE.
- Lane i fires at cycle t when en[i] && value[i]==t.
  - STEP=0: spikes_out[i] is high only in that cycle.
  - STEP=1: spikes_out[i] is high in every cycle with t>=value[i] for the rest of the window.
- Lanes with value[i]>=GAMMA never fire. This is not an error.
- IDLE: spikes_out=0, busy=0, win_start=0, win_done=0.
- in_values and in_en are ignored when no accept occurs. Captured data stays constant for the whole window.

## Timing
- All outputs are registered, and all outputs reset to 0 asynchronously. State resets to IDLE, and t and the captured registers reset to 0. in_ready is combinational from state and t, so it reads 1 during reset.
- Latency: an accept at edge E makes window cycle t=0 visible in the cycle after E. A lane with value v fires in the (v+1)th cycle after the accept edge.
- Back-to-back: accept during t==GAMMA-1 gives t=0 of the next window in the immediately following cycle. STEP levels clear at that boundary unless the new value is 0.
- win_start and win_done are each exactly one cycle per window. Both are high in the same cycle only when GAMMA... is never 1 (GAMMA>=2), so they never coincide.
- Reset mid-window aborts the window: spikes_out drops to 0 immediately, and no win_done is issued.
- in_valid held high continuously gives continuous windows with busy stuck at 1.

## Structure
- Shared package spike_pkg:
  - enc_state_t enum {IDLE, RUN}.
  - Default GAMMA and VBITS localparams, kept consistent with `num_spikes and `WBITS from internal_defines.vh.
- Sub-module spike_lane, instantiated N times via generate. Per lane it holds the captured value and enable, does the compare against t, and keeps the STEP hold flop. It takes t, a load strobe and a window-start strobe from the parent.
- The parent holds the FSM, the t counter, the handshake and the window flags.

## Test plan
- Reset then idle: rst_n low for 3 cycles, then high with in_valid=0 → spikes_out=0, busy=0, in_ready=1 for 10 cycles.
- Pulse encode, N=4, STEP=0, values {0,3,7,3}, in_en=4'b1111: lane0 fires at t0, lanes1/3 at t3, lane2 at t7. Each pulse lasts 1 cycle. win_start at t0, win_done at t7, then IDLE.
- Step encode, same values, STEP=1: lane1 is high t3..t7, lane2 high only at t7, lane0 high t0..t7. All lanes are 0 in the cycle after win_done.
- Enables and out-of-window values: in_en=4'b0101 with values {2,2,2,2} → only lanes 0 and 2 fire, at t2. GAMMA=6 with value 7 → that lane stays silent and the window lasts 6 cycles.
- Back-to-back: in_valid held high with windows A={1,1,1,1} and B={0,0,0,0} → B's t0 spikes appear the cycle right after A's win_done. busy never drops, and exactly 2 win_start pulses are seen.
- Reset mid-window: assert rst_n=0 at t4 → spikes_out, busy and win_done go to 0 without waiting for an edge. After release, the next accept starts cleanly at t0.
